// File: rtl/audio_pkg.sv
// Shared widths, sample limits and frame packing for the audio frame packer.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 24;
  localparam int unsigned FRAME_W    = 2 * SAMPLE_W;
  localparam int unsigned GAIN_W     = 8;
  localparam int unsigned GAIN_FRAC  = 7;
  localparam int unsigned GAIN_UNITY = 128;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned PROD_W     = SAMPLE_W + GAIN_W + 1;

  localparam logic [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

  // Left channel occupies the upper half of the FIFO word.
  localparam int unsigned FRAME_LEFT_LSB  = SAMPLE_W;
  localparam int unsigned FRAME_RIGHT_LSB = 0;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [GAIN_W-1:0]   gain_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } frame_t;

  function automatic frame_t pack_frame(input sample_t left, input sample_t right);
    logic [FRAME_W-1:0] word;
    word = '0;
    word[FRAME_LEFT_LSB  +: SAMPLE_W] = left;
    word[FRAME_RIGHT_LSB +: SAMPLE_W] = right;
    return frame_t'(word);
  endfunction

endpackage

// File: rtl/audio_frame_packer_if.sv
// Sample input handshake, FIFO write port and saturation diagnostics.
interface audio_frame_packer_if;
  import audio_pkg::*;

  logic                s_valid;
  logic                s_ready;
  sample_t             s_left;
  sample_t             s_right;
  gain_t               gain_left;
  gain_t               gain_right;
  logic                mute;
  frame_t              frame_out;
  logic                write_frame;
  logic                full;
  logic [CNT_W-1:0]    sat_count;
  logic                sat_clear;

  modport master (
    output s_valid, s_left, s_right, gain_left, gain_right, mute, full, sat_clear,
    input  s_ready, frame_out, write_frame, sat_count
  );

  modport slave (
    input  s_valid, s_left, s_right, gain_left, gain_right, mute, full, sat_clear,
    output s_ready, frame_out, write_frame, sat_count
  );

endinterface

// File: rtl/audio_gain_sat.sv
// One channel: S1 gain multiply register, S2 round-half-up / saturate register.
module audio_gain_sat
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    s1_load,
  input  logic    s2_load,
  input  sample_t sample,
  input  gain_t   gain,
  input  logic    mute,
  output sample_t result,
  output logic    sat_c
);

  localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(2 ** (GAIN_FRAC - 1));
  localparam logic signed [PROD_W-1:0] R_MAX      = PROD_W'(SAMPLE_MAX);
  localparam logic signed [PROD_W-1:0] R_MIN      = {{(PROD_W-SAMPLE_W){1'b1}}, SAMPLE_MIN};

  logic signed [PROD_W-1:0] sample_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] s1_prod;
  logic signed [PROD_W-1:0] rnd_sum;
  logic signed [PROD_W-1:0] rnd_val;
  logic                     sat_hi;
  logic                     sat_lo;
  sample_t                  sat_val_c;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  always_comb begin
    sample_ext = PROD_W'($signed(sample));
    gain_ext   = $signed(PROD_W'(gain));
    prod_c     = mute ? '0 : sample_ext * gain_ext;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_prod <= '0;
    end else if (s1_load) begin
      s1_prod <= prod_c;
    end
  end

  // Arithmetic shift after the half-LSB bias rounds ties toward +inf.
  always_comb begin
    rnd_sum = s1_prod + ROUND_BIAS;
    rnd_val = rnd_sum >>> GAIN_FRAC;
    sat_hi  = rnd_val > R_MAX;
    sat_lo  = rnd_val < R_MIN;
    sat_c   = sat_hi || sat_lo;
    if (sat_hi) begin
      sat_val_c = SAMPLE_MAX;
    end else if (sat_lo) begin
      sat_val_c = SAMPLE_MIN;
    end else begin
      sat_val_c = rnd_val[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result <= '0;
    end else if (s2_load) begin
      result <= sat_val_c;
    end
  end

endmodule

// File: rtl/audio_frame_packer.sv
// Gain/saturate stereo pairs in a two-stage pipeline and feed the I2S FIFO write port.
module audio_frame_packer
  import audio_pkg::*;
(
  input  logic                 clk_soc,
  input  logic                 reset,
  audio_frame_packer_if.slave  bus
);

  logic             adv;
  logic             accept;
  logic             s1_valid;
  logic             s2_valid;
  logic             s2_load;
  logic             sat_left_c;
  logic             sat_right_c;
  logic             frame_sat_c;
  sample_t          left_res;
  sample_t          right_res;
  logic [CNT_W-1:0] sat_cnt;

  // A single advance enable stalls both stages together while S2 waits on the FIFO.
  always_comb begin
    adv         = !s2_valid || !bus.full;
    accept      = bus.s_valid && adv;
    s2_load     = adv && s1_valid;
    frame_sat_c = s2_load && (sat_left_c || sat_right_c);
  end

  assign bus.s_ready     = adv;
  assign bus.write_frame = s2_valid && !bus.full;
  assign bus.frame_out   = pack_frame(left_res, right_res);
  assign bus.sat_count   = sat_cnt;

  always_ff @(posedge clk_soc) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
    end
  end

  // Clear has priority; the count sticks at all-ones.
  always_ff @(posedge clk_soc) begin
    if (reset) begin
      sat_cnt <= '0;
    end else if (bus.sat_clear) begin
      sat_cnt <= '0;
    end else if (frame_sat_c && (sat_cnt != '1)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

  audio_gain_sat u_left (
    .clk     (clk_soc),
    .reset   (reset),
    .s1_load (accept),
    .s2_load (s2_load),
    .sample  (bus.s_left),
    .gain    (bus.gain_left),
    .mute    (bus.mute),
    .result  (left_res),
    .sat_c   (sat_left_c)
  );

  audio_gain_sat u_right (
    .clk     (clk_soc),
    .reset   (reset),
    .s1_load (accept),
    .s2_load (s2_load),
    .sample  (bus.s_right),
    .gain    (bus.gain_right),
    .mute    (bus.mute),
    .result  (right_res),
    .sat_c   (sat_right_c)
  );

endmodule

// File: tb/tb_audio_frame_packer.sv
// Self-checking bench for audio_frame_packer: vector table, directed corner sequences, random scoreboard.
module tb_audio_frame_packer;

  logic clk = 1'b0;
  logic reset;

  audio_frame_packer_if bus ();

  audio_frame_packer dut (
    .clk_soc (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_sat  = 0;
  logic [47:0] exp_q[$];

  typedef struct {
    logic [23:0] left;
    logic [23:0] right;
    logic [7:0]  gl;
    logic [7:0]  gr;
    logic        mute;
    logic [47:0] frame;
    int          sat_total;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference for one channel: exact integer arithmetic, floor((x*g + 64) / 128), then clamp.
  function automatic logic [24:0] ref_ch(input logic [23:0] s, input logic [7:0] g, input logic m);
    longint p;
    longint v;
    longint q;
    p = m ? 64'sd0 : longint'($signed(s)) * longint'(g);
    v = p + 64;
    q = (v >= 0) ? (v / 128) : -((-v + 127) / 128);
    if (q > 8388607)       return {1'b1, 24'h7FFFFF};
    else if (q < -8388608) return {1'b1, 24'h800000};
    else                   return {1'b0, 24'(q)};
  endfunction

  function automatic logic [23:0] rand_sample();
    logic [23:0] picks[5];
    picks[0] = 24'h7FFFFF; picks[1] = 24'h800000; picks[2] = 24'h000000;
    picks[3] = 24'h000001; picks[4] = 24'hFFFFFF;
    if ($urandom_range(0, 3) == 0) return picks[$urandom_range(0, 4)];
    return 24'($urandom);
  endfunction

  // Scoreboard: every accepted pair is modelled at acceptance; every write must match in order.
  always @(negedge clk) begin
    logic [24:0] l;
    logic [24:0] r;
    if (reset) begin
      exp_q.delete();
      exp_sat = 0;
    end else begin
      if (bus.write_frame) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected write_frame: got frame %h, required no write (t=%0t)",
                   bus.frame_out, $time);
        end else begin
          check("scoreboard frame", 64'(bus.frame_out), 64'(exp_q.pop_front()));
        end
      end
      if (bus.s_valid && bus.s_ready) begin
        l = ref_ch(bus.s_left, bus.gain_left, bus.mute);
        r = ref_ch(bus.s_right, bus.gain_right, bus.mute);
        exp_q.push_back({l[23:0], r[23:0]});
        if ((l[24] || r[24]) && exp_sat != 65535) exp_sat++;
      end
      if (bus.sat_clear) exp_sat = 0;
    end
  end

  task automatic set_pair(input logic [23:0] l, input logic [23:0] r,
                          input logic [7:0] gl, input logic [7:0] gr, input logic m);
    bus.s_left = l; bus.s_right = r; bus.gain_left = gl; bus.gain_right = gr; bus.mute = m;
  endtask

  initial begin
    vecs[0] = '{24'h123456, 24'hFEDCBA, 8'd128, 8'd128, 1'b0, 48'h123456FEDCBA, 0};
    vecs[1] = '{24'h000003, 24'hFFFFFD, 8'd64,  8'd64,  1'b0, 48'h000002FFFFFF, 0};
    vecs[2] = '{24'h7FFFFF, 24'h800000, 8'd255, 8'd255, 1'b0, 48'h7FFFFF800000, 1};
    vecs[3] = '{24'h7FFFFF, 24'h800000, 8'd255, 8'd255, 1'b0, 48'h7FFFFF800000, 2};
    vecs[4] = '{24'h7FFFFF, 24'h800000, 8'd255, 8'd255, 1'b1, 48'h000000000000, 2};
    vecs[5] = '{24'h123456, 24'h800000, 8'd0,   8'd0,   1'b0, 48'h000000000000, 2};
    vecs[6] = '{24'h010000, 24'hFF0000, 8'd255, 8'd255, 1'b0, 48'h01FE00FE0200, 2};
    vecs[7] = '{24'h7F8000, 24'h000001, 8'd129, 8'd128, 1'b0, 48'h7FFFFF000001, 3};
    vecs[8] = '{24'h7FFFFF, 24'h800000, 8'd128, 8'd128, 1'b0, 48'h7FFFFF800000, 3};
    vecs[9] = '{24'h000001, 24'hFFFFFF, 8'd64,  8'd64,  1'b0, 48'h000001000000, 3};

    reset = 1'b1;
    bus.s_valid = 1'b0; bus.full = 1'b0; bus.sat_clear = 1'b0;
    set_pair(24'h0, 24'h0, 8'd128, 8'd128, 1'b0);
    next_cycle();
    @(negedge clk);
    check("reset s_ready", 64'(bus.s_ready), 64'd1);
    check("reset write_frame", 64'(bus.write_frame), 64'd0);
    check("reset frame_out", 64'(bus.frame_out), 64'd0);
    check("reset sat_count", 64'(bus.sat_count), 64'd0);
    next_cycle();
    reset = 1'b0;

    // Single-pair vectors: latency 2, frame value and running saturation count.
    foreach (vecs[i]) begin
      set_pair(vecs[i].left, vecs[i].right, vecs[i].gl, vecs[i].gr, vecs[i].mute);
      bus.s_valid = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d s_ready", i), 64'(bus.s_ready), 64'd1);
      next_cycle();
      bus.s_valid = 1'b0;
      set_pair(24'($urandom), 24'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      @(negedge clk);
      check($sformatf("vec%0d write N+1", i), 64'(bus.write_frame), 64'd0);
      next_cycle();
      @(negedge clk);
      check($sformatf("vec%0d write N+2", i), 64'(bus.write_frame), 64'd1);
      check($sformatf("vec%0d frame", i), 64'(bus.frame_out), 64'(vecs[i].frame));
      check($sformatf("vec%0d sat_count", i), 64'(bus.sat_count), 64'(vecs[i].sat_total));
      next_cycle();
    end

    // sat_clear takes effect on the following cycle.
    bus.sat_clear = 1'b1;
    @(negedge clk);
    check("sat_clear same cycle", 64'(bus.sat_count), 64'd3);
    next_cycle();
    bus.sat_clear = 1'b0;
    @(negedge clk);
    check("sat_clear next cycle", 64'(bus.sat_count), 64'd0);
    next_cycle();

    // Backpressure: pairs 1..5 streamed, full held for 10 cycles after the first write.
    begin
      int idx;
      idx = 1;
      set_pair(24'h0, 24'h0, 8'd128, 8'd128, 1'b0);
      for (int c = 0; c < 18; c++) begin
        bus.full    = (c >= 3 && c <= 12);
        bus.s_valid = (idx <= 5);
        bus.s_left  = 24'(idx);
        bus.s_right = 24'(idx + 256);
        @(negedge clk);
        if (c >= 3 && c <= 12) begin
          check($sformatf("bp c%0d s_ready", c), 64'(bus.s_ready), 64'd0);
          check($sformatf("bp c%0d write", c), 64'(bus.write_frame), 64'd0);
        end
        if (c == 2 || (c >= 13 && c <= 16)) begin
          int k;
          k = (c == 2) ? 1 : c - 11;
          check($sformatf("bp c%0d write", c), 64'(bus.write_frame), 64'd1);
          check($sformatf("bp c%0d frame", c), 64'(bus.frame_out), {16'h0, 24'(k), 24'(k + 256)});
        end
        if (c == 17) check("bp drained", 64'(bus.write_frame), 64'd0);
        if (bus.s_valid && bus.s_ready) idx++;
        next_cycle();
      end
      bus.full = 1'b0;
      bus.s_valid = 1'b0;
    end

    // Mute and gain are captured at acceptance only.
    set_pair(24'h111111, 24'h222222, 8'd128, 8'd128, 1'b1);
    bus.s_valid = 1'b1;
    next_cycle();
    set_pair(24'h345678, 24'hCBA987, 8'd128, 8'd128, 1'b0);
    next_cycle();
    bus.s_valid = 1'b0;
    set_pair(24'h0, 24'h0, 8'd255, 8'd255, 1'b1);
    @(negedge clk);
    check("mute A write", 64'(bus.write_frame), 64'd1);
    check("mute A frame", 64'(bus.frame_out), 64'd0);
    next_cycle();
    @(negedge clk);
    check("gain B write", 64'(bus.write_frame), 64'd1);
    check("gain B frame", 64'(bus.frame_out), 64'h345678CBA987);
    next_cycle();

    // Reset with two saturating frames held behind a full FIFO.
    set_pair(24'h7FFFFF, 24'h000001, 8'd255, 8'd255, 1'b0);
    bus.s_valid = 1'b1;
    next_cycle();
    set_pair(24'h7FFFFF, 24'h7FFFFF, 8'd255, 8'd255, 1'b0);
    next_cycle();
    bus.s_valid = 1'b0;
    bus.full = 1'b1;
    @(negedge clk);
    check("rst held write", 64'(bus.write_frame), 64'd0);
    check("rst held s_ready", 64'(bus.s_ready), 64'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check("rst pre sat_count", 64'(bus.sat_count), 64'd1);
    next_cycle();
    reset = 1'b0;
    bus.full = 1'b0;
    set_pair(24'h0ABCDE, 24'h0F0F0F, 8'd128, 8'd128, 1'b0);
    bus.s_valid = 1'b1;
    @(negedge clk);
    check("rst post write", 64'(bus.write_frame), 64'd0);
    check("rst post s_ready", 64'(bus.s_ready), 64'd1);
    check("rst post sat_count", 64'(bus.sat_count), 64'd0);
    check("rst post frame_out", 64'(bus.frame_out), 64'd0);
    next_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
    check("rst C N+1 write", 64'(bus.write_frame), 64'd0);
    next_cycle();
    @(negedge clk);
    check("rst C N+2 write", 64'(bus.write_frame), 64'd1);
    check("rst C frame", 64'(bus.frame_out), 64'h0ABCDE0F0F0F);
    next_cycle();

    // Random traffic with random backpressure, checked by the scoreboard.
    for (int c = 0; c < 600; c++) begin
      bus.s_valid = ($urandom_range(0, 9) < 7);
      set_pair(rand_sample(), rand_sample(), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), ($urandom_range(0, 9) == 0));
      bus.full = ($urandom_range(0, 9) < 3);
      next_cycle();
    end
    bus.s_valid = 1'b0;
    bus.full = 1'b0;
    for (int c = 0; c < 4; c++) next_cycle();
    @(negedge clk);
    check("random sat_count", 64'(bus.sat_count), 64'(exp_sat));
    check("random pending frames", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
